// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised synchronous FIFO.
//   - default width/depth constants used as top-level parameter defaults
//   - pointer/index width helpers (pointer = index bits + one wrap bit)
//   - full/empty pointer compare
//   - packed status bundle
package fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned ptr_w_of(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

    // Returns {full, empty} for two pw-bit pointers zero-extended to 32 bits.
    function automatic logic [1:0] ptr_cmp(input logic [31:0]  wp,
                                           input logic [31:0]  rp,
                                           input int unsigned  pw);
        logic [31:0] diff;
        logic [31:0] idx_mask;
        logic        idx_eq;
        logic        wrap_ne;
        diff     = wp ^ rp;
        idx_mask = (32'd1 << (pw - 1)) - 32'd1;
        idx_eq   = ((diff & idx_mask) == 32'd0);
        wrap_ne  = (((diff >> (pw - 1)) & 32'd1) == 32'd1);
        return {idx_eq && wrap_ne, diff == 32'd0};
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one synchronous write port and
// one combinational read port. Contents are never reset.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational)
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and overflow/underflow pulses.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through: dout shows
// the head word combinationally; otherwise dout is registered (1-cycle
// latency after an accepted read, holds otherwise, 0 after reset).
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   wr, din       write request and data
//   rd, dout      read request and data
//   empty, full   occupancy 0 / DEPTH
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned PTR_W = ptr_w_of(DEPTH);
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_acc;
    logic              rd_acc;
    logic              mem_we;
    logic [1:0]        cmp_c;
    logic [DATA_W-1:0] rdata;
    fifo_status_t      status_c;

    assign cmp_c = ptr_cmp(32'(wr_ptr_q), 32'(rd_ptr_q), PTR_W);

    // Status bundle: full/empty from pointers, thresholds from registered count.
    always_comb begin
        status_c              = '0;
        status_c.full         = cmp_c[1];
        status_c.empty        = cmp_c[0];
        status_c.almost_full  = (count_q >= PTR_W'(AF_LEVEL));
        status_c.almost_empty = (count_q <= PTR_W'(AE_LEVEL));
        status_c.overflow     = ovf_q;
        status_c.underflow    = udf_q;
    end

    // Acceptance, pointer/count update and error pulses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A read on a full FIFO frees the slot the simultaneous write uses.
        wr_acc   = wr & (~status_c.full | rd);
        rd_acc   = rd & ~status_c.empty;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = wr & ~wr_acc;
        udf_d = rd & ~rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Writes in a reset cycle are dropped.
    assign mem_we = rst & wr_acc;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i (din),
        .raddr_i (rd_ptr_q[IDX_W-1:0]),
        .rdata_o (rdata)
    );

`ifdef FIFO_FWFT_EN
    // Head word falls through; undefined while empty.
    assign dout = rdata;
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    // Capture the head on an accepted read, hold otherwise.
    always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`endif

    assign empty        = status_c.empty;
    assign full         = status_c.full;
    assign almost_full  = status_c.almost_full;
    assign almost_empty = status_c.almost_empty;
    assign overflow     = status_c.overflow;
    assign underflow    = status_c.underflow;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a DEPTH=16 and a DEPTH=4 instance share the
// same stimulus; a circular-buffer reference model per instance tracks the
// expected contents, count, error pulses and registered read data.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout16, dout4;
    logic       empty16, full16, af16, ae16, ovf16, udf16;
    logic       empty4, full4, af4, ae4, ovf4, udf4;
    logic [4:0] count16;
    logic [2:0] count4;

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 -> DEPTH 16, index 1 -> DEPTH 4.
    logic [7:0] mbuf [2][16];
    int         mhead [2];
    int         mcnt  [2];
    logic [7:0] mdout [2];
    logic       movf  [2];
    logic       mudf  [2];

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_W(8), .DEPTH(16)) u16 (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout16),
        .empty(empty16), .full(full16), .almost_full(af16), .almost_empty(ae16),
        .count(count16), .overflow(ovf16), .underflow(udf16)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout4),
        .empty(empty4), .full(full4), .almost_full(af4), .almost_empty(ae4),
        .count(count4), .overflow(ovf4), .underflow(udf4)
    );

    task automatic model_update;
        for (int k = 0; k < 2; k++) begin
            int   dep;
            logic wacc;
            logic racc;
            dep = (k == 0) ? 16 : 4;
            if (!rst) begin
                mcnt[k]  = 0;
                mhead[k] = 0;
                mdout[k] = 8'h00;
                movf[k]  = 1'b0;
                mudf[k]  = 1'b0;
            end else begin
                wacc = wr && ((mcnt[k] != dep) || rd);
                racc = rd && (mcnt[k] != 0);
                if (racc) begin
                    mdout[k] = mbuf[k][mhead[k]];
                    mhead[k] = (mhead[k] + 1) % dep;
                    mcnt[k]  = mcnt[k] - 1;
                end
                if (wacc) begin
                    mbuf[k][(mhead[k] + mcnt[k]) % dep] = din;
                    mcnt[k] = mcnt[k] + 1;
                end
                movf[k] = wr && !wacc;
                mudf[k] = rd && !racc;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1ns later.
    task automatic step(input logic r_n, input logic w, input logic r, input logic [7:0] d);
        rst = r_n;
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        total++;
        if ({count16, empty16, full16, af16, ae16, ovf16, udf16} !== {5'd0, 6'b100100}) begin
            bad++;
            $display("FAIL reset16 status: got %b want %b",
                     {count16, empty16, full16, af16, ae16, ovf16, udf16}, {5'd0, 6'b100100});
        end
        total++;
        if ({count4, empty4, full4, af4, ae4, ovf4, udf4} !== {3'd0, 6'b100100}) begin
            bad++;
            $display("FAIL reset4 status: got %b want %b",
                     {count4, empty4, full4, af4, ae4, ovf4, udf4}, {3'd0, 6'b100100});
        end
`ifndef FIFO_FWFT_EN
        total++;
        if (dout16 !== 8'h00) begin
            bad++;
            $display("FAIL reset16 dout: got %h want 00", dout16);
        end
`endif
    endtask

    task automatic test_basic;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(i + 1));
            total++;
            if (count16 !== 5'(i + 1)) begin
                bad++;
                $display("FAIL basic count after write %0d: got %0d want %0d", i, count16, i + 1);
            end
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
`ifdef FIFO_FWFT_EN
            if (i < 4) begin
                total++;
                if (dout16 !== 8'(i + 2)) begin
                    bad++;
                    $display("FAIL basic fwft head after read %0d: got %h want %h", i, dout16, 8'(i + 2));
                end
            end
`else
            total++;
            if (dout16 !== 8'(i + 1)) begin
                bad++;
                $display("FAIL basic dout after read %0d: got %h want %h", i, dout16, 8'(i + 1));
            end
`endif
            total++;
            if (count16 !== 5'(4 - i)) begin
                bad++;
                $display("FAIL basic count after read %0d: got %0d want %0d", i, count16, 4 - i);
            end
        end
        total++;
        if (empty16 !== 1'b1) begin
            bad++;
            $display("FAIL basic empty at end: got %b want 1", empty16);
        end
    endtask

    task automatic test_fill4;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i));
            total++;
            if ({count4, af4} !== {3'(i + 1), (i >= 1)}) begin
                bad++;
                $display("FAIL fill4 count/af write %0d: got %0d/%b want %0d/%b",
                         i, count4, af4, i + 1, (i >= 1));
            end
        end
        total++;
        if (full4 !== 1'b1) begin
            bad++;
            $display("FAIL fill4 full: got %b want 1", full4);
        end
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        total++;
        if ({ovf4, count4, full4} !== {1'b1, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL fill4 overflow: got ovf=%b cnt=%0d full=%b want 1/4/1", ovf4, count4, full4);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        total++;
        if (ovf4 !== 1'b0) begin
            bad++;
            $display("FAIL fill4 overflow pulse width: got %b want 0", ovf4);
        end
        for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
            total++;
            if (dout4 !== 8'hA0 + 8'(i)) begin
                bad++;
                $display("FAIL fill4 fwft head %0d: got %h want %h", i, dout4, 8'hA0 + 8'(i));
            end
            step(1'b1, 1'b0, 1'b1, 8'h00);
`else
            step(1'b1, 1'b0, 1'b1, 8'h00);
            total++;
            if (dout4 !== 8'hA0 + 8'(i)) begin
                bad++;
                $display("FAIL fill4 read %0d: got %h want %h", i, dout4, 8'hA0 + 8'(i));
            end
`endif
        end
        total++;
        if (empty4 !== 1'b1) begin
            bad++;
            $display("FAIL fill4 empty after drain: got %b want 1", empty4);
        end
    endtask

    task automatic test_underflow;
        step(1'b1, 1'b0, 1'b1, 8'h00);
        total++;
        if ({udf4, count4, empty4} !== {1'b1, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL underflow pulse: got udf=%b cnt=%0d empty=%b want 1/0/1", udf4, count4, empty4);
        end
`ifndef FIFO_FWFT_EN
        total++;
        if (dout4 !== 8'hA3) begin
            bad++;
            $display("FAIL underflow dout held: got %h want a3", dout4);
        end
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00);
        total++;
        if (udf4 !== 1'b0) begin
            bad++;
            $display("FAIL underflow pulse width: got %b want 0", udf4);
        end
    endtask

    task automatic test_wrap;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'($urandom));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'($urandom));
            total++;
            if ({count4, full4} !== {3'd4, 1'b1}) begin
                bad++;
                $display("FAIL wrap count/full cyc %0d: got %0d/%b want 4/1", i, count4, full4);
            end
`ifdef FIFO_FWFT_EN
            total++;
            if (dout4 !== mbuf[1][mhead[1]]) begin
                bad++;
                $display("FAIL wrap fwft head cyc %0d: got %h want %h", i, dout4, mbuf[1][mhead[1]]);
            end
`else
            total++;
            if (dout4 !== mdout[1]) begin
                bad++;
                $display("FAIL wrap dout cyc %0d: got %h want %h", i, dout4, mdout[1]);
            end
`endif
        end
        for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
            total++;
            if (dout4 !== mbuf[1][mhead[1]]) begin
                bad++;
                $display("FAIL wrap drain fwft %0d: got %h want %h", i, dout4, mbuf[1][mhead[1]]);
            end
            step(1'b1, 1'b0, 1'b1, 8'h00);
`else
            step(1'b1, 1'b0, 1'b1, 8'h00);
            total++;
            if (dout4 !== mdout[1]) begin
                bad++;
                $display("FAIL wrap drain %0d: got %h want %h", i, dout4, mdout[1]);
            end
`endif
        end
        total++;
        if (empty4 !== 1'b1) begin
            bad++;
            $display("FAIL wrap empty after drain: got %b want 1", empty4);
        end
    endtask

    task automatic test_reset_mid;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h30 + 8'(i));
        end
        total++;
        if (count4 !== 3'd3) begin
            bad++;
            $display("FAIL reset_mid pre count: got %0d want 3", count4);
        end
        step(1'b0, 1'b1, 1'b1, 8'h77);
        total++;
        if ({count4, empty4} !== {3'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid state: got cnt=%0d empty=%b want 0/1", count4, empty4);
        end
`ifndef FIFO_FWFT_EN
        total++;
        if (dout4 !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid dout: got %h want 00", dout4);
        end
`endif
        step(1'b1, 1'b1, 1'b0, 8'h55);
`ifdef FIFO_FWFT_EN
        total++;
        if (dout4 !== 8'h55) begin
            bad++;
            $display("FAIL reset_mid fwft head: got %h want 55", dout4);
        end
`endif
        step(1'b1, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
        total++;
        if (dout4 !== 8'h55) begin
            bad++;
            $display("FAIL reset_mid read: got %h want 55", dout4);
        end
`endif
        total++;
        if (empty4 !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid empty: got %b want 1", empty4);
        end
    endtask

    task automatic test_fwft;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef FIFO_FWFT_EN
        total++;
        if ({dout16, empty16} !== {8'h11, 1'b0}) begin
            bad++;
            $display("FAIL fwft no-rd head: got %h/%b want 11/0", dout16, empty16);
        end
`else
        total++;
        if ({dout16, empty16} !== {8'h00, 1'b0}) begin
            bad++;
            $display("FAIL fwft no-rd hold: got %h/%b want 00/0", dout16, empty16);
        end
`endif
        step(1'b1, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
        total++;
        if (dout16 !== 8'h11) begin
            bad++;
            $display("FAIL fwft registered read: got %h want 11", dout16);
        end
`endif
        total++;
        if (empty16 !== 1'b1) begin
            bad++;
            $display("FAIL fwft empty after rd: got %b want 1", empty16);
        end
    endtask

    task automatic test_random;
        logic [10:0] e16, a16;
        logic [8:0]  e4, a4;
        int          wp;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            wp = (((i / 40) % 2) == 0) ? 75 : 30;
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < (100 - wp)), 8'($urandom));
            e16 = {5'(mcnt[0]), mcnt[0] == 0, mcnt[0] == 16, mcnt[0] >= 14, mcnt[0] <= 2, movf[0], mudf[0]};
            a16 = {count16, empty16, full16, af16, ae16, ovf16, udf16};
            total++;
            if (a16 !== e16) begin
                bad++;
                $display("FAIL rand16 status cyc %0d: got %b want %b", i, a16, e16);
            end
            e4 = {3'(mcnt[1]), mcnt[1] == 0, mcnt[1] == 4, mcnt[1] >= 2, mcnt[1] <= 2, movf[1], mudf[1]};
            a4 = {count4, empty4, full4, af4, ae4, ovf4, udf4};
            total++;
            if (a4 !== e4) begin
                bad++;
                $display("FAIL rand4 status cyc %0d: got %b want %b", i, a4, e4);
            end
`ifdef FIFO_FWFT_EN
            if (mcnt[0] != 0) begin
                total++;
                if (dout16 !== mbuf[0][mhead[0]]) begin
                    bad++;
                    $display("FAIL rand16 head cyc %0d: got %h want %h", i, dout16, mbuf[0][mhead[0]]);
                end
            end
            if (mcnt[1] != 0) begin
                total++;
                if (dout4 !== mbuf[1][mhead[1]]) begin
                    bad++;
                    $display("FAIL rand4 head cyc %0d: got %h want %h", i, dout4, mbuf[1][mhead[1]]);
                end
            end
`else
            total++;
            if (dout16 !== mdout[0]) begin
                bad++;
                $display("FAIL rand16 dout cyc %0d: got %h want %h", i, dout16, mdout[0]);
            end
            total++;
            if (dout4 !== mdout[1]) begin
                bad++;
                $display("FAIL rand4 dout cyc %0d: got %h want %h", i, dout4, mdout[1]);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill4();
        test_underflow();
        test_wrap();
        test_reset_mid();
        test_fwft();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
